uart_buffered_tx: RTL and testbench

//  FIFO-buffered RS232 transmitter for the TX side of the UART subsystem. Fabric logic pushes bytes

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_buffered_tx.sv | 127 ++++++++++++
 tb/tb_uart_buffered_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, word-length limits, oversampling default
// and the word-length clamp used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [3:0] NBITS_MIN = 4'd5;
  localparam logic [3:0] NBITS_MAX = 4'd8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       par_en;
    logic       par_odd;
  } frame_t;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    if (n < NBITS_MIN)      return NBITS_MIN;
    else if (n > NBITS_MAX) return NBITS_MAX;
    else                    return n;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push is ignored when full,
// pop is ignored when empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// FIFO-buffered UART transmitter: 5..8 data bits, optional parity, one stop bit,
// bit timing from a 16x oversampling tick.
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic [3:0] NBits,
  input  logic       ParityEn,
  input  logic       ParityOdd,
  input  logic [7:0] WrData,
  input  logic       WrEn,
  output logic       Full,
  output logic       Empty,
  output logic       Overflow,
  output logic       Busy,
  output logic       TxDone,
  output logic       Tx
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             pop;
  logic             have_data;

  logic [2:0] state;
  frame_t     frame;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       last_data_bit;
  logic [7:0] data_mask;
  logic       frame_parity;

  uart_sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .push    (WrEn),
    .wr_data (WrData),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign Full          = fifo_full;
  assign Empty         = fifo_empty;
  assign Busy          = (state != ST_IDLE);
  assign have_data     = (fifo_count != '0);
  assign bit_end       = Tick && (tick_cnt == TICK_LAST);
  assign last_data_bit = ({1'b0, bit_idx} == (frame.nbits - 4'd1));
  assign data_mask     = 8'hFF >> (4'd8 - frame.nbits);
  assign frame_parity  = (^(frame.data & data_mask)) ^ frame.par_odd;

  // Pop from IDLE at once, or chain straight out of a completing stop bit.
  assign pop = have_data && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      frame    <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      Tx       <= 1'b1;
      TxDone   <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      if (pop) begin
        frame    <= '{data: fifo_rd_data, nbits: clamp_nbits(NBits),
                      par_en: ParityEn, par_odd: ParityOdd};
        tick_cnt <= '0;
        bit_idx  <= '0;
        state    <= ST_START;
        Tx       <= 1'b0;
        if (state == ST_STOP) TxDone <= 1'b1;
      end else if ((state != ST_IDLE) && Tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 4'd1;
        if (bit_end) begin
          case (state)
            ST_START: begin
              state <= ST_DATA;
              Tx    <= frame.data[0];
            end
            ST_DATA: begin
              if (last_data_bit) begin
                if (frame.par_en) begin
                  state <= ST_PARITY;
                  Tx    <= frame_parity;
                end else begin
                  state <= ST_STOP;
                  Tx    <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                Tx      <= frame.data[bit_idx + 3'd1];
              end
            end
            ST_PARITY: begin
              state <= ST_STOP;
              Tx    <= 1'b1;
            end
            ST_STOP: begin
              state  <= ST_IDLE;
              TxDone <= 1'b1;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 Overflow <= 1'b0;
    else if (WrEn && fifo_full) Overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Bench for uart_buffered_tx: table of frame formats plus sequences for back-to-back,
// full/overflow, mid-frame reset and mid-frame NBits change, checked by a line decoder.
module tb_uart_buffered_tx;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Tick = 1'b0;
  logic [3:0] NBits = 4'd8;
  logic       ParityEn = 1'b0;
  logic       ParityOdd = 1'b0;
  logic [7:0] WrData = '0;
  logic       WrEn = 1'b0;
  logic       Full, Empty, Overflow, Busy, TxDone, Tx;

  int checks = 0;
  int failures = 0;

  uart_buffered_tx #(.FIFO_AW(4), .OVERSAMPLE(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .NBits(NBits), .ParityEn(ParityEn),
    .ParityOdd(ParityOdd), .WrData(WrData), .WrEn(WrEn), .Full(Full), .Empty(Empty),
    .Overflow(Overflow), .Busy(Busy), .TxDone(TxDone), .Tx(Tx)
  );

  typedef struct {
    logic [7:0]  rx;
    int unsigned n;
    logic        pen;
    logic        par;
    int unsigned len;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       pen;
    logic       podd;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];

  initial forever #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] rx, input int unsigned n, input logic pen,
                                  input logic par, input int unsigned len);
    exp_t e;
    e.rx = rx; e.n = n; e.pen = pen; e.par = par; e.len = len;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] d, input logic [3:0] nb, input logic pen,
                                  input logic podd, input exp_t e);
    vec_t v;
    v.data = d; v.nbits = nb; v.pen = pen; v.podd = podd; v.exp = e;
    return v;
  endfunction

  // Tick generator: one pulse every 4 clocks while enabled
  bit          tick_en = 1'b1;
  int unsigned tick_total = 0;
  initial begin
    int unsigned div = 0;
    forever begin
      @(negedge Clk);
      div = (div + 1) % 4;
      Tick = tick_en && (div == 0);
      if (Tick) tick_total++;
    end
  end

  // Line decoder: samples each bit mid-period, checks the frame when TxDone fires
  bit          in_frame = 1'b0;
  bit          prev_done = 1'b0;
  int unsigned mticks = 0;
  int unsigned done_count = 0;
  logic        bits [12];
  exp_t        cur;

  task automatic finish_frame();
    logic [7:0] rx = '0;
    check("frame_len", mticks, cur.len);
    check("start_bit", bits[0], 1'b0);
    for (int unsigned i = 0; i < cur.n; i++) rx[i] = bits[1 + i];
    check("data", rx, cur.rx);
    if (cur.pen) check("parity", bits[1 + cur.n], cur.par);
    check("stop_bit", bits[1 + cur.n + (cur.pen ? 1 : 0)], 1'b1);
  endtask

  initial begin
    logic t;
    forever begin
      @(posedge Clk);
      t = Tick;
      @(negedge Clk);
      if (!Rst_n) begin
        in_frame  = 1'b0;
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) check("txdone_width", TxDone, 1'b0);
      prev_done = TxDone;
      if (in_frame && t) begin
        mticks++;
        if ((mticks % 16 == 8) && (mticks / 16 < 12)) bits[mticks / 16] = Tx;
        if (mticks > 16 * 12) begin
          check("frame_len_bound", mticks, cur.len);
          in_frame = 1'b0;
        end
      end
      if (TxDone) begin
        done_count++;
        check("txdone_in_frame", in_frame, 1'b1);
        if (in_frame) begin
          finish_frame();
          in_frame = 1'b0;
          if (sb.size() > 0) check("b2b_start", Tx, 1'b0);
        end
      end
      if (!in_frame && Tx === 1'b0) begin
        check("frame_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          in_frame = 1'b1;
          mticks = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input exp_t e);
    WrData = d;
    WrEn = 1'b1;
    sb.push_back(e);
    @(negedge Clk);
    WrEn = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!(sb.size() == 0 && !in_frame && !Busy && Empty) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_idle"}, n < budget, 1'b1);
  endtask

  task automatic wait_busy(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!Busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_busy"}, Busy, 1'b1);
  endtask

  task automatic wait_ticks(input int unsigned cnt);
    int unsigned target = tick_total + cnt;
    int unsigned n = 0;
    while (tick_total < target && n < cnt * 8 + 16) begin
      @(negedge Clk);
      n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    int unsigned d0;

    tbl[0] = mk_vec(8'hA5, 4'd8,  1'b0, 1'b0, mk_exp(8'hA5, 8, 1'b0, 1'b0, 160));
    tbl[1] = mk_vec(8'h83, 4'd7,  1'b1, 1'b0, mk_exp(8'h03, 7, 1'b1, 1'b0, 160));
    tbl[2] = mk_vec(8'h83, 4'd7,  1'b1, 1'b1, mk_exp(8'h03, 7, 1'b1, 1'b1, 160));
    tbl[3] = mk_vec(8'h1B, 4'd2,  1'b1, 1'b0, mk_exp(8'h1B, 5, 1'b1, 1'b0, 128));
    tbl[4] = mk_vec(8'hF0, 4'd12, 1'b1, 1'b1, mk_exp(8'hF0, 8, 1'b1, 1'b1, 176));
    tbl[5] = mk_vec(8'h3C, 4'd6,  1'b0, 1'b0, mk_exp(8'h3C, 6, 1'b0, 1'b0, 128));
    tbl[6] = mk_vec(8'h00, 4'd8,  1'b1, 1'b1, mk_exp(8'h00, 8, 1'b1, 1'b1, 176));
    tbl[7] = mk_vec(8'h81, 4'd8,  1'b1, 1'b0, mk_exp(8'h81, 8, 1'b1, 1'b0, 176));
    tbl[8] = mk_vec(8'hFF, 4'd0,  1'b0, 1'b0, mk_exp(8'h1F, 5, 1'b0, 1'b0, 112));

    repeat (3) @(negedge Clk);
    check("rst_tx", Tx, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_txdone", TxDone, 1'b0);
    check("rst_full", Full, 1'b0);
    check("rst_empty", Empty, 1'b1);
    check("rst_overflow", Overflow, 1'b0);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 9; i++) begin
      NBits = tbl[i].nbits;
      ParityEn = tbl[i].pen;
      ParityOdd = tbl[i].podd;
      d0 = done_count;
      push(tbl[i].data, tbl[i].exp);
      wait_idle("vec", 2000);
      check("vec_done_pulses", done_count - d0, 1);
    end

    // back-to-back frames
    NBits = 4'd8; ParityEn = 1'b0; ParityOdd = 1'b0;
    d0 = done_count;
    push(8'h55, mk_exp(8'h55, 8, 1'b0, 1'b0, 160));
    push(8'h0F, mk_exp(8'h0F, 8, 1'b0, 1'b0, 160));
    push(8'hFF, mk_exp(8'hFF, 8, 1'b0, 1'b0, 160));
    wait_idle("b2b", 3000);
    check("b2b_done_pulses", done_count - d0, 3);
    check("b2b_empty", Empty, 1'b1);

    // fill with Tick stalled, then overflow
    tick_en = 1'b0;
    repeat (2) @(negedge Clk);
    d0 = done_count;
    for (int unsigned i = 0; i < 17; i++)
      push(8'h10 + 8'(i), mk_exp(8'h10 + 8'(i), 8, 1'b0, 1'b0, 160));
    check("fill_full", Full, 1'b1);
    check("fill_busy", Busy, 1'b1);
    check("fill_overflow_pre", Overflow, 1'b0);
    WrData = 8'hEE;
    WrEn = 1'b1;
    @(negedge Clk);
    WrEn = 1'b0;
    check("overflow_set", Overflow, 1'b1);
    check("overflow_full", Full, 1'b1);
    tick_en = 1'b1;
    wait_idle("drain", 20000);
    check("drain_done_pulses", done_count - d0, 17);
    check("overflow_sticky", Overflow, 1'b1);

    // reset in the middle of data bit 3 with another byte queued
    push(8'hC3, mk_exp(8'hC3, 8, 1'b0, 1'b0, 160));
    push(8'h3C, mk_exp(8'h3C, 8, 1'b0, 1'b0, 160));
    wait_busy("rst_mid", 100);
    wait_ticks(16 + 3 * 16 + 8);
    d0 = done_count;
    #1 Rst_n = 1'b0;
    #1;
    check("midrst_tx", Tx, 1'b1);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_empty", Empty, 1'b1);
    check("midrst_txdone", TxDone, 1'b0);
    check("midrst_overflow", Overflow, 1'b0);
    sb.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (200) @(negedge Clk);
    check("midrst_no_done", done_count - d0, 0);
    check("midrst_tx_idle", Tx, 1'b1);
    d0 = done_count;
    push(8'h5A, mk_exp(8'h5A, 8, 1'b0, 1'b0, 160));
    wait_idle("resume", 2000);
    check("resume_done_pulses", done_count - d0, 1);

    // NBits change while a frame is in flight
    d0 = done_count;
    NBits = 4'd8;
    push(8'h96, mk_exp(8'h96, 8, 1'b0, 1'b0, 160));
    wait_busy("nbchg", 100);
    NBits = 4'd5;
    push(8'hE7, mk_exp(8'h07, 5, 1'b0, 1'b0, 112));
    wait_idle("nbchg", 3000);
    check("nbchg_done_pulses", done_count - d0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
